// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: two-port round-robin sequencer for one OpenRAM 1RW macro.
// Port 0 is the Wishbone slave side, port 1 the user datapath.
// Optional spare data bit 32 is enabled with the SRAM_ARB_SPARE_EN macro.
//
// Handshake: a requester raises pN_req_i with stable fields and holds them
// until pN_ack_o pulses for one cycle. A granted access always completes,
// even if req drops early. Read data appears on pN_rdata_o with the ack and
// is held until that port's next read.
//
// Every access takes ISSUE -> WAIT -> DONE. csb0 is low only during ISSUE,
// so the macro samples exactly once per access. dout0 is captured at the end
// of WAIT. In DONE the finishing port's own req is masked, because it is
// still high during its ack cycle.
module sram_1rw_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4,
`ifdef SRAM_ARB_SPARE_EN
    localparam int DW = NUM_WMASKS * 8 + 1
`else
    localparam int DW = NUM_WMASKS * 8
`endif
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  p0_req_i,
    input  logic                  p0_we_i,
    input  logic [NUM_WMASKS-1:0] p0_wmask_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DW-1:0]         p0_wdata_i,
    output logic                  p0_ack_o,
    output logic [DW-1:0]         p0_rdata_o,
    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [NUM_WMASKS-1:0] p1_wmask_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DW-1:0]         p1_wdata_i,
    output logic                  p1_ack_o,
    output logic [DW-1:0]         p1_rdata_o,
`ifdef SRAM_ARB_SPARE_EN
    input  logic                  p0_spare_we_i,
    input  logic                  p1_spare_we_i,
`endif
    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic                  sram_spare_wen0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DW-1:0]         sram_din0_o,
    input  logic [DW-1:0]         sram_dout0_i,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state, state_n;
    logic   owner;        // port currently being served
    logic   owner_we;     // served access is a write
    logic   last_grant;   // last port granted; the other one wins a tie

    logic                  req0_eff, req1_eff;
    logic                  load;
    logic                  pick;
    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DW-1:0]         sel_wdata;

    assign dbg_state = state;

    // Next-state, arbitration and field selection.
    always_comb begin
        state_n   = state;
        req0_eff  = p0_req_i & ~((state == ST_DONE) && (owner == 1'b0));
        req1_eff  = p1_req_i & ~((state == ST_DONE) && (owner == 1'b1));
        pick      = (req0_eff && req1_eff) ? ~last_grant : req1_eff;
        load      = 1'b0;
        sel_we    = pick ? p1_we_i    : p0_we_i;
        sel_wmask = pick ? p1_wmask_i : p0_wmask_i;
        sel_addr  = pick ? p1_addr_i  : p0_addr_i;
        sel_wdata = pick ? p1_wdata_i : p0_wdata_i;
        case (state)
            ST_IDLE: begin
                if (req0_eff || req1_eff) begin
                    load    = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT:  state_n = ST_DONE;
            ST_DONE: begin
                if (req0_eff || req1_eff) begin
                    load    = 1'b1;
                    state_n = ST_ISSUE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register, macro pin flops, acks and read-data capture.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
            owner_we      <= 1'b0;
            last_grant    <= 1'b1;
            sram_csb0_o   <= 1'b1;
            sram_web0_o   <= 1'b1;
            sram_wmask0_o <= '0;
            sram_addr0_o  <= '0;
            sram_din0_o   <= '0;
            p0_ack_o      <= 1'b0;
            p1_ack_o      <= 1'b0;
            p0_rdata_o    <= '0;
            p1_rdata_o    <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                owner         <= pick;
                owner_we      <= sel_we;
                last_grant    <= pick;
                sram_csb0_o   <= 1'b0;
                sram_web0_o   <= ~sel_we;
                sram_wmask0_o <= sel_wmask;
                sram_addr0_o  <= sel_addr;
                sram_din0_o   <= sel_wdata;
            end else if (state == ST_ISSUE) begin
                sram_csb0_o <= 1'b1;
                sram_web0_o <= 1'b1;
            end
            p0_ack_o <= (state == ST_WAIT) && (owner == 1'b0);
            p1_ack_o <= (state == ST_WAIT) && (owner == 1'b1);
            if ((state == ST_WAIT) && !owner_we) begin
                if (owner == 1'b0) p0_rdata_o <= sram_dout0_i;
                else               p1_rdata_o <= sram_dout0_i;
            end
        end
    end

`ifdef SRAM_ARB_SPARE_EN
    // Spare-bit write enable follows the other pins: set on load, cleared after ISSUE.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sram_spare_wen0_o <= 1'b0;
        end else if (load) begin
            sram_spare_wen0_o <= sel_we & (pick ? p1_spare_we_i : p0_spare_we_i);
        end else if (state == ST_ISSUE) begin
            sram_spare_wen0_o <= 1'b0;
        end
    end
`else
    assign sram_spare_wen0_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed testbench for sram_1rw_arbiter with a behavioural 1RW macro model.
`timescale 1ns/1ps
module tb_sram_1rw_arbiter;
`ifdef SRAM_ARB_SPARE_EN
    localparam int DW = 33;
`else
    localparam int DW = 32;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          p0_req, p0_we, p1_req, p1_we;
    logic [3:0]    p0_wmask, p1_wmask;
    logic [9:0]    p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
`ifdef SRAM_ARB_SPARE_EN
    logic          p0_spare_we, p1_spare_we;
`endif
    logic          sram_csb0, sram_web0, sram_spare_wen0;
    logic [3:0]    sram_wmask0;
    logic [9:0]    sram_addr0;
    logic [DW-1:0] sram_din0, sram_dout0;
    logic [1:0]    dbg_state;

    sram_1rw_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_wmask_i(p0_wmask),
        .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_ack_o(p0_ack), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_wmask_i(p1_wmask),
        .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata),
`ifdef SRAM_ARB_SPARE_EN
        .p0_spare_we_i(p0_spare_we), .p1_spare_we_i(p1_spare_we),
`endif
        .sram_csb0_o(sram_csb0), .sram_web0_o(sram_web0),
        .sram_wmask0_o(sram_wmask0), .sram_spare_wen0_o(sram_spare_wen0),
        .sram_addr0_o(sram_addr0), .sram_din0_o(sram_din0),
        .sram_dout0_i(sram_dout0), .dbg_state(dbg_state)
    );

    // macro model: samples pins at posedge when selected
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wmask0[i]) mem[sram_addr0][i*8 +: 8] <= sram_din0[i*8 +: 8];
`ifdef SRAM_ARB_SPARE_EN
                if (sram_spare_wen0) mem[sram_addr0][32] <= sram_din0[32];
`endif
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    // scoreboard
    int            n_vec = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic          spare_seen;
    int            k, lat, cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one access on one port, checks latency, csb pulse and read data
    task automatic access(input string tag, input bit port, input bit we, input logic [3:0] wm,
                          input logic [9:0] a, input logic [DW-1:0] wd, input bit sp);
        int l;
        int c;
        logic [DW-1:0] e;
        if (port == 1'b0) begin
            p0_we = we; p0_wmask = wm; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_wmask = wm; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
        end
`ifdef SRAM_ARB_SPARE_EN
        p0_spare_we = sp; p1_spare_we = sp;
`else
        if (sp) spare_seen = spare_seen;
`endif
        l = -1;
        c = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (!sram_csb0) c++;
            if (sram_spare_wen0) spare_seen = 1'b1;
            if ((port == 1'b0 && p0_ack) || (port == 1'b1 && p1_ack)) begin
                l = n;
                break;
            end
        end
        check({tag, "_latency"}, l, 3);
        check({tag, "_csb_low_cycles"}, c, 1);
        if (!we) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, port ? p1_rdata : p0_rdata, e);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_csb0"}, sram_csb0, 1);
        check({tag, "_web0"}, sram_web0, 1);
        check({tag, "_wmask0"}, sram_wmask0, 0);
        check({tag, "_spare_wen0"}, sram_spare_wen0, 0);
        check({tag, "_addr0"}, sram_addr0, 0);
        check({tag, "_din0"}, sram_din0, 0);
        check({tag, "_acks"}, {p0_ack, p1_ack}, 0);
        check({tag, "_p0_rdata"}, p0_rdata, 0);
        check({tag, "_p1_rdata"}, p1_rdata, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_wmask = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_wmask = 0; p1_addr = 0; p1_wdata = 0;
`ifdef SRAM_ARB_SPARE_EN
        p0_spare_we = 0; p1_spare_we = 0;
`endif
        spare_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst_init");
        rst = 1'b0;
        @(posedge clk); #1;

        // p0 write then read back at 0x155
        access("t2_wr", 0, 1, 4'hF, 10'h155, 'hDEADBEEF, 0);
        exp_q.push_back('hDEADBEEF);
        access("t2_rd", 0, 0, 4'h0, 10'h155, '0, 0);

        // p1 at top address: full write, byte-1 write, empty-mask write, read
        access("t3_wr_full", 1, 1, 4'hF, 10'h3FF, 'h11223344, 0);
        access("t3_wr_byte1", 1, 1, 4'b0010, 10'h3FF, 'hAABBCCDD, 0);
        access("t3_wr_nomask", 1, 1, 4'h0, 10'h3FF, 'hFFFFFFFF, 0);
        exp_q.push_back('h1122CC44);
        access("t3_rd", 1, 0, 4'h0, 10'h3FF, '0, 0);
        check("t3_p0_rdata_held", p0_rdata, 'hDEADBEEF);

        // both ports held: p0 reads, p1 writes; grants alternate every 3 cycles
        p0_we = 0; p0_addr = 10'h155; p0_wmask = 4'h0;
        p1_we = 1; p1_addr = 10'h3FF; p1_wmask = 4'hF; p1_wdata = 'h55667788;
        p0_req = 1; p1_req = 1;
        k = 0;
        for (int n = 0; n < 20 && k < 4; n++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                check("t4_ack_port", p1_ack, k % 2);
                check("t4_ack_cycle", n, 3 + 3 * k);
                check("t4_single_ack", p0_ack & p1_ack, 0);
                check("t4_p1_rdata_untouched", p1_rdata, 'h1122CC44);
                if (p0_ack) check("t4_p0_rdata", p0_rdata, 'hDEADBEEF);
                k++;
                if (k == 4) begin
                    p0_req = 0;
                    p1_req = 0;
                end
            end
        end
        check("t4_ack_count", k, 4);
        p0_req = 0; p1_req = 0;
        @(posedge clk); #1;
        exp_q.push_back('h55667788);
        access("t4_rd_back", 0, 0, 4'h0, 10'h3FF, '0, 0);
        check("t4_p1_rdata_after", p1_rdata, 'h1122CC44);

        // p1 drops req right after being granted; access still completes once
        p1_we = 0; p1_addr = 10'h155; p1_req = 1;
        cnt = 0; lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 1) p1_req = 0;
            if (p1_ack) begin
                cnt++;
                if (lat < 0) lat = n;
            end
        end
        check("t5_ack_count", cnt, 1);
        check("t5_ack_cycle", lat, 3);
        check("t5_p1_rdata", p1_rdata, 'hDEADBEEF);
        @(posedge clk); #1;

        // spare bit
`ifdef SRAM_ARB_SPARE_EN
        access("t6_wr_set", 0, 1, 4'hF, 10'h010, 33'h1_0000_0000, 1);
        access("t6_wr_keep", 0, 1, 4'hF, 10'h010, 33'h0_0000_0000, 0);
        exp_q.push_back(33'h1_0000_0000);
        access("t6_rd", 0, 0, 4'h0, 10'h010, '0, 0);
`else
        spare_seen = 1'b0;
        access("t6_wr", 0, 1, 4'hF, 10'h010, 'h12345678, 1);
        check("t6_spare_wen_idle", spare_seen, 0);
`endif

        // reset in the middle of an access
        p0_we = 1; p0_wmask = 4'hF; p0_addr = 10'h020; p0_wdata = 'hCAFEF00D; p0_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("t1_csb_low_in_issue", sram_csb0, 0);
        rst = 1'b1;
        #1;
        check_reset_values("t1_rst_mid");
        p0_req = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 0) check("t1_csb_after_rst", sram_csb0, 1);
            if (!sram_csb0 || p0_ack || p1_ack) cnt++;
        end
        check("t1_quiet_after_rst", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
